// File: rtl/adc_record_unpacker.sv
// Purpose: validates 129-bit ADC trigger records, tags burst starts, buffers them and emits each as four 32-bit words.
// Latency: a record accepted in cycle t into an empty FIFO with the output idle gives its first word valid in cycle t+2.
// Backpressure: s_axis_tready falls while the FIFO is full and arriving records are dropped; m_axis_tready stalls the word sequencer.
module adc_record_unpacker #(
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter int          PACKET_RECORDS  = 64,
    parameter logic [15:0] MARKER          = 16'hA1B2
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    input  logic [128:0]             s_axis_tdata,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tlast,
    input  logic                     flush,
    input  logic                     clear_stats,
    output logic [31:0]              records_received,
    output logic [31:0]              records_dropped,
    output logic [31:0]              marker_errors,
    output logic [15:0]              bursts_count,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    // Entry layout: [112:49] C, [48:33] A, [32:17] B, [16:1] S, [0] start
    localparam int EW    = 113;
    localparam int PCW   = $clog2(PACKET_RECORDS) + 1;
    localparam logic [PCW-1:0] PKT_LAST = PCW'(PACKET_RECORDS - 1);
    localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);

    typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

    state_t          state, state_nx;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   hold;
    logic [EW-1:0]   wr_entry;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [63:0]     last_c, c_in;
    logic [PCW-1:0]  packet_cnt;
    logic            started, have_last, flush_pend;
    logic            full, empty, marker_ok, wr_en, drop_en, merr_en, start_bit;
    logic            pop, out_hs, last_hs;
    logic            unused_msb;

    assign unused_msb    = s_axis_tdata[128];
    assign full          = (fifo_level == LVL_FULL);
    assign empty         = (fifo_level == '0);
    // Ready only once out of reset; full is judged on the registered level, so a same-cycle pop frees nothing
    assign s_axis_tready = started & ~full;
    assign marker_ok     = (s_axis_tdata[15:0] == MARKER);
    // A bad marker is always a marker error, even when the FIFO is full
    assign merr_en       = s_axis_tvalid & ~marker_ok;
    assign wr_en         = s_axis_tvalid & marker_ok & s_axis_tready;
    assign drop_en       = s_axis_tvalid & marker_ok & ~s_axis_tready;
    assign c_in          = s_axis_tdata[127:64];
    // 64-bit addition wraps, so C=0 following C=2^64-1 counts as contiguous
    assign start_bit     = ~have_last | (c_in != last_c + 64'd1);
    assign wr_entry      = {c_in, s_axis_tdata[63:16], start_bit};

    assign m_axis_tvalid = (state != IDLE);
    assign out_hs        = m_axis_tvalid & m_axis_tready;
    assign last_hs       = out_hs & m_axis_tlast;

    // Marks the first clock after reset release so the source sees ready only then
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) started <= 1'b0;
        else          started <= 1'b1;
    end

    // Record storage; contents need no reset because occupancy is tracked separately
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    // FIFO pointers, occupancy and the output holding register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            hold       <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                hold   <= mem[rd_ptr];
            end
            fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
        end
    end

    // Burst continuity tracking; a drop breaks continuity so the next accepted record starts a burst
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            have_last <= 1'b0;
            last_c    <= '0;
        end else if (wr_en) begin
            have_last <= 1'b1;
            last_c    <= c_in;
        end else if (drop_en) begin
            have_last <= 1'b0;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            records_received <= '0;
            records_dropped  <= '0;
            marker_errors    <= '0;
            bursts_count     <= '0;
        end else if (clear_stats) begin
            records_received <= '0;
            records_dropped  <= '0;
            marker_errors    <= '0;
            bursts_count     <= '0;
        end else begin
            if (wr_en && records_received != '1)            records_received <= records_received + 32'd1;
            if (drop_en && records_dropped != '1)           records_dropped  <= records_dropped + 32'd1;
            if (merr_en && marker_errors != '1)             marker_errors    <= marker_errors + 32'd1;
            if (wr_en && start_bit && bursts_count != '1)   bursts_count     <= bursts_count + 16'd1;
        end
    end

    // Word sequencer state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and pop: W3 chains straight into the next record when one is waiting
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop      = 1'b1;
                state_nx = W0;
            end
            W0: if (out_hs) state_nx = W1;
            W1: if (out_hs) state_nx = W2;
            W2: if (out_hs) state_nx = W3;
            W3: if (out_hs) begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = W0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Word selection from the holding register; stable while stalled since hold only loads on pop
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
        case (state)
            W0: m_axis_tdata = hold[80:49];
            W1: m_axis_tdata = hold[112:81];
            W2: m_axis_tdata = hold[48:17];
            W3: begin
                m_axis_tdata = {hold[16:1], 15'b0, hold[0]};
                m_axis_tlast = (packet_cnt == PKT_LAST) | flush_pend;
            end
            default: m_axis_tdata = '0;
        endcase
    end

    // Packet framing: count records per packet; a flush closes the open packet at the next W3
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            packet_cnt <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (last_hs)
                packet_cnt <= '0;
            else if (out_hs && state == W3)
                packet_cnt <= packet_cnt + PCW'(1);
            if (last_hs)
                flush_pend <= 1'b0;
            else if (flush && (state != IDLE || packet_cnt != '0))
                flush_pend <= 1'b1;
        end
    end
endmodule
